// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - fetch-to-decode instruction FIFO with one-cycle mispredict flush
module fetch_decode_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    input  logic                       in_pred_taken,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    output logic                       out_pred_taken,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage, split per field; contents are never cleared, only pointers
    logic [XLEN-1:0] r_pc_mem   [DEPTH];
    logic [XLEN-1:0] r_inst_mem [DEPTH];
    logic            r_pred_mem [DEPTH];

    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_enq;
    logic            w_deq;

    // Full/empty come only from the occupancy register, so there is no
    // same-cycle bypass from a dequeue into in_ready.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A flush drops both handshakes of its cycle.
    assign w_enq = in_valid && !w_full && !flush;
    assign w_deq = out_ready && !w_empty && !flush;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;

    // Head entry read straight from storage, forced to NOP defaults when empty
    always_comb begin
        out_pc         = '0;
        out_inst       = NOP_INST;
        out_pred_taken = 1'b0;
        if (!w_empty) begin
            out_pc         = r_pc_mem[r_head];
            out_inst       = r_inst_mem[r_head];
            out_pred_taken = r_pred_mem[r_head];
        end
    end

    // Write the incoming instruction into the tail slot on an accepted enqueue
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            r_pc_mem[r_tail]   <= in_pc;
            r_inst_mem[r_tail] <= in_inst;
            r_pred_mem[r_tail] <= in_pred_taken;
        end
    end

    // Pointer and occupancy update; reset beats flush beats handshakes
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
